// File: rtl/wb_interconnect_1n.sv
// Wishbone single-master, N-slave interconnect: address decode, request fanout,
// response return, decode-error and stall-timeout terminations.
module wb_interconnect_1n #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {32'h1000_0000, 32'h3000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {32'hFFFF_F000, 32'hF000_0000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [ADDR_WIDTH-1:0]                 M_ADR_O,
  input  logic [DATA_WIDTH-1:0]                 M_DAT_O,
  input  logic                                  M_WE_O,
  input  logic                                  M_STB_O,
  input  logic                                  M_CYC_O,
  input  logic [DATA_WIDTH/8-1:0]               M_SEL_O,
  output logic [DATA_WIDTH-1:0]                 M_DAT_I,
  output logic                                  M_ACK_I,
  output logic                                  M_ERR_I,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]      S_ADR_I,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]      S_DAT_I,
  output logic [NUM_SLAVES*(DATA_WIDTH/8)-1:0]  S_SEL_I,
  output logic [NUM_SLAVES-1:0]                 S_WE_I,
  output logic [NUM_SLAVES-1:0]                 S_STB_I,
  output logic [NUM_SLAVES-1:0]                 S_CYC_I,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]      S_DAT_O,
  input  logic [NUM_SLAVES-1:0]                 S_ACK_O,
  input  logic [NUM_SLAVES-1:0]                 S_ERR_O,
  output logic                                  busy_o,
  output logic                                  decode_err_o,
  output logic                                  timeout_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACTIVE, DERR, TOUT} state_t;

  state_t                state;
  logic [IDX_WIDTH-1:0]  idx;
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  hit;
  logic [IDX_WIDTH-1:0]  win;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  sel_ack;
  logic                  sel_err;
  logic                  term;
  logic                  stall_limit;

  // Descending scan so the lowest matching index is the last one written.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((M_ADR_O & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        win = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    sel_ack = 1'b0;
    sel_err = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IDX_WIDTH'(i)) begin
        sel_dat = S_DAT_O[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ack = S_ACK_O[i];
        sel_err = S_ERR_O[i];
      end
    end
  end

  assign term        = sel_ack | sel_err;
  assign stall_limit = (TIMEOUT_CYCLES > 0) && (cnt == CNT_LIMIT);

  // Only the granted slave sees the master; every other slave is held at zero.
  always_comb begin
    S_ADR_I = '0;
    S_DAT_I = '0;
    S_SEL_I = '0;
    S_WE_I  = '0;
    S_STB_I = '0;
    S_CYC_I = '0;
    if (state == ACTIVE) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (idx == IDX_WIDTH'(i)) begin
          S_ADR_I[i*ADDR_WIDTH +: ADDR_WIDTH] = M_ADR_O;
          S_DAT_I[i*DATA_WIDTH +: DATA_WIDTH] = M_DAT_O;
          S_SEL_I[i*SEL_WIDTH +: SEL_WIDTH]   = M_SEL_O;
          S_WE_I[i]  = M_WE_O;
          S_STB_I[i] = M_STB_O;
          S_CYC_I[i] = M_CYC_O;
        end
      end
    end
  end

  // A dropped CYC abandons the cycle, so a late slave response is not forwarded.
  always_comb begin
    M_DAT_I = '0;
    M_ACK_I = 1'b0;
    M_ERR_I = 1'b0;
    case (state)
      ACTIVE: begin
        M_DAT_I = sel_dat;
        if (M_CYC_O) begin
          M_ERR_I = sel_err;
          M_ACK_I = sel_ack & ~sel_err;
        end
      end
      DERR, TOUT: M_ERR_I = 1'b1;
      default: ;
    endcase
  end

  assign busy_o       = (state != IDLE);
  assign decode_err_o = (state == DERR);
  assign timeout_o    = (state == TOUT);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (M_STB_O && M_CYC_O) begin
            if (hit) begin
              idx   <= win;
              cnt   <= '0;
              state <= ACTIVE;
            end else begin
              state <= DERR;
            end
          end
        end
        ACTIVE: begin
          if (!term) cnt <= cnt + 1'b1;
          if (!M_CYC_O)         state <= IDLE;
          else if (term)        state <= IDLE;
          else if (stall_limit) state <= TOUT;
        end
        DERR:    state <= IDLE;
        TOUT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
